// File: rtl/jtdd_vtimer.sv
// Video timing generator: pixel/line counters, blanking and sync flags,
// CPU bus-phase strobes, line-compare interrupt and frame-start pulse.
module jtdd_vtimer #(
    parameter int unsigned HW       = 9,
    parameter int unsigned VW       = 9,
    parameter int unsigned HMAX     = 383,
    parameter int unsigned VMIN     = 8,
    parameter int unsigned VMAX     = 279,
    parameter int unsigned HB_START = 256,
    parameter int unsigned HB_END   = 0,
    parameter int unsigned HS_START = 309,
    parameter int unsigned HS_END   = 329,
    parameter int unsigned VB_START = 248,
    parameter int unsigned VB_END   = 8,
    parameter int unsigned VS_START = 258,
    parameter int unsigned VS_END   = 262,
    parameter int unsigned PHASES   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pxl_cen,
    input  logic              flip,
    input  logic [VW-1:0]     irq_line,
    output logic [HW-1:0]     HPOS,
    output logic [VW-1:0]     VPOS,
    output logic              HBL,
    output logic              VBL,
    output logic              HS,
    output logic              VS,
    output logic [PHASES-1:0] M,
    output logic              LIRQ,
    output logic              FRAME
);

    logic [HW-1:0]     hn;
    logic [HW-1:0]     hn_nx;
    logic [VW-1:0]     vn;
    logic [VW-1:0]     vn_nx;
    logic              wrap;
    logic              hbl_nx;
    logic              hs_nx;
    logic              vbl_nx;
    logic              vs_nx;
    logic              lirq_nx;
    logic              frame_nx;
    logic [PHASES-1:0] m_nx;

    // Next-state values for every register, applied on the next pixel enable
    always_comb begin
        wrap     = 1'b0;
        hn_nx    = hn;
        vn_nx    = vn;
        hbl_nx   = HBL;
        hs_nx    = HS;
        vbl_nx   = VBL;
        vs_nx    = VS;
        m_nx     = '0;
        lirq_nx  = 1'b0;
        frame_nx = 1'b0;

        wrap  = (hn == HW'(HMAX));
        hn_nx = wrap ? '0 : hn + HW'(1);
        if (wrap) begin
            vn_nx = (vn == VW'(VMAX)) ? VW'(VMIN) : vn + VW'(1);
        end

        // Set is evaluated last so it overrides a coincident clear
        if (hn_nx == HW'(HB_END)) hbl_nx = 1'b0;
        if (hn == HW'(HB_START))  hbl_nx = 1'b1;

        if (hn == HW'(HS_START))    hs_nx = 1'b1;
        else if (hn == HW'(HS_END)) hs_nx = 1'b0;

        if (wrap) begin
            if (vn_nx == VW'(VB_START))    vbl_nx = 1'b1;
            else if (vn_nx == VW'(VB_END)) vbl_nx = 1'b0;
        end

        if (hn == HW'(HS_START)) begin
            if (vn == VW'(VS_START))    vs_nx = 1'b1;
            else if (vn == VW'(VS_END)) vs_nx = 1'b0;
        end

        // One strobe per odd count; slot index is hn[3:1], unused slots stay low
        for (int k = 0; k < PHASES; k++) begin
            m_nx[k] = hn_nx[0] && (hn_nx[3:1] == 3'(k));
        end

        lirq_nx  = (hn == HW'(HB_START)) && (vn == irq_line);
        frame_nx = wrap && !VBL && vbl_nx;
    end

    // State registers; everything holds while pxl_cen is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hn    <= '0;
            vn    <= VW'(VMIN);
            HBL   <= 1'b0;
            VBL   <= 1'b0;
            HS    <= 1'b0;
            VS    <= 1'b0;
            M     <= '0;
            LIRQ  <= 1'b0;
            FRAME <= 1'b0;
        end else if (pxl_cen) begin
            hn    <= hn_nx;
            vn    <= vn_nx;
            HBL   <= hbl_nx;
            VBL   <= vbl_nx;
            HS    <= hs_nx;
            VS    <= vs_nx;
            M     <= m_nx;
            LIRQ  <= lirq_nx;
            FRAME <= frame_nx;
        end
    end

    // Flip mirrors the counters with no added latency
    assign HPOS = hn ^ {HW{flip}};
    assign VPOS = vn ^ {VW{flip}};

endmodule

// File: tb/tb_jtdd_vtimer.sv
// Directed bench for jtdd_vtimer: default-size timer for line, flip, gating
// and reset behaviour; a shrunken timer for whole-frame behaviour.
module tb_jtdd_vtimer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic       d_rst_n, d_cen, d_flip;
    logic [8:0] d_irq, d_hpos, d_vpos;
    logic       d_hbl, d_vbl, d_hs, d_vs, d_lirq, d_frame;
    logic [5:0] d_m;

    jtdd_vtimer u_d (
        .clk(clk), .rst_n(d_rst_n), .pxl_cen(d_cen), .flip(d_flip), .irq_line(d_irq),
        .HPOS(d_hpos), .VPOS(d_vpos), .HBL(d_hbl), .VBL(d_vbl), .HS(d_hs), .VS(d_vs),
        .M(d_m), .LIRQ(d_lirq), .FRAME(d_frame)
    );

    // small instance: 32 counts per line, lines 8..40
    logic       s_rst_n, s_cen, s_flip;
    logic [8:0] s_irq, s_hpos, s_vpos;
    logic       s_hbl, s_vbl, s_hs, s_vs, s_lirq, s_frame;
    logic [3:0] s_m;

    jtdd_vtimer #(
        .HMAX(31), .VMIN(8), .VMAX(40), .HB_START(24), .HB_END(0),
        .HS_START(26), .HS_END(29), .VB_START(36), .VB_END(8),
        .VS_START(37), .VS_END(39), .PHASES(4)
    ) u_s (
        .clk(clk), .rst_n(s_rst_n), .pxl_cen(s_cen), .flip(s_flip), .irq_line(s_irq),
        .HPOS(s_hpos), .VPOS(s_vpos), .HBL(s_hbl), .VBL(s_vbl), .HS(s_hs), .VS(s_vs),
        .M(s_m), .LIRQ(s_lirq), .FRAME(s_frame)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] m6_model(input logic [8:0] h);
        return (h[0] && h[3:1] < 3'd6) ? 6'd1 << h[3:1] : 6'd0;
    endfunction

    function automatic logic [3:0] m4_model(input logic [8:0] h);
        return (h[0] && h[3:1] < 3'd4) ? 4'd1 << h[3:1] : 4'd0;
    endfunction

    // event recorders, default instance
    logic        d_rec = 1'b0;
    logic        p_hbl = 1'b0, p_hs = 1'b0;
    logic [31:0] d_hbl_rise = '1, d_hbl_fall = '1, d_hs_rise = '1, d_lirq_pos = '1;
    int          d_hs_len = 0, d_lirq_cnt = 0, d_m_bad = 0, d_m_hot = 0;

    task automatic d_tick();
        @(posedge clk); #1;
        if (d_rec) begin
            if (d_hbl && !p_hbl) d_hbl_rise = 32'(d_hpos);
            if (!d_hbl && p_hbl) d_hbl_fall = 32'(d_hpos);
            if (d_hs && !p_hs)   d_hs_rise  = 32'(d_hpos);
            if (d_hs)            d_hs_len++;
            if (d_lirq) begin
                d_lirq_cnt++;
                d_lirq_pos = 32'({d_vpos, d_hpos});
            end
            if (d_m !== m6_model(d_hpos)) d_m_bad++;
            if ($countones(d_m) > 1)      d_m_hot++;
        end
        p_hbl = d_hbl;
        p_hs  = d_hs;
    endtask

    // event recorders, small instance
    logic        q_vbl = 1'b0, q_vs = 1'b0, q_hbl = 1'b0;
    logic [31:0] s_vbl_rise = '1, s_vbl_fall = '1, s_vs_rise = '1, s_vs_fall = '1;
    logic [31:0] s_frame_pos = '1, s_lirq_pos = '1, s_hbl_rise = '1;
    int          s_frame_cnt = 0, s_lirq_cnt = 0, s_m_bad = 0;

    task automatic s_tick();
        @(posedge clk); #1;
        if (s_vbl && !q_vbl) s_vbl_rise = 32'({s_vpos, s_hpos});
        if (!s_vbl && q_vbl) s_vbl_fall = 32'({s_vpos, s_hpos});
        if (s_vs && !q_vs)   s_vs_rise  = 32'({s_vpos, s_hpos});
        if (!s_vs && q_vs)   s_vs_fall  = 32'({s_vpos, s_hpos});
        if (s_hbl && !q_hbl) s_hbl_rise = 32'(s_hpos);
        if (s_frame) begin
            s_frame_cnt++;
            s_frame_pos = 32'({s_vpos, s_hpos});
        end
        if (s_lirq) begin
            s_lirq_cnt++;
            s_lirq_pos = 32'({s_vpos, s_hpos});
        end
        if (s_m !== m4_model(s_hpos)) s_m_bad++;
        q_vbl = s_vbl;
        q_vs  = s_vs;
        q_hbl = s_hbl;
    endtask

    int          freeze_bad = 0;
    logic [8:0]  eh;

    initial begin
        d_rst_n = 1'b0; d_cen = 1'b1; d_flip = 1'b0; d_irq = 9'd8;
        s_rst_n = 1'b0; s_cen = 1'b1; s_flip = 1'b0; s_irq = 9'd20;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_hpos", 32'(d_hpos), 0);
        check("rst_vpos", 32'(d_vpos), 8);
        check("rst_flags", 32'({d_hbl, d_vbl, d_hs, d_vs, d_lirq, d_frame}), 0);
        check("rst_m", 32'(d_m), 0);

        // first line at defaults
        d_rst_n = 1'b1;
        d_rec   = 1'b1;
        d_tick();
        check("first_count", 32'(d_hpos), 1);
        check("m_slot0", 32'(d_m), 32'h01);
        repeat (10) d_tick();
        check("m_slot5", 32'(d_m), 32'h20);
        repeat (2) d_tick();
        check("m_slot6_empty", 32'(d_m), 0);
        repeat (370) d_tick();
        check("line_end_pos", 32'({d_vpos, d_hpos}), 32'({9'd8, 9'd383}));
        d_tick();
        check("wrap_pos", 32'({d_vpos, d_hpos}), 32'({9'd9, 9'd0}));
        check("hbl_rise", d_hbl_rise, 257);
        check("hbl_fall", d_hbl_fall, 0);
        check("hs_rise", d_hs_rise, 310);
        check("hs_len", 32'(d_hs_len), 20);
        check("m_pattern", 32'(d_m_bad), 0);
        check("m_two_hot", 32'(d_m_hot), 0);
        check("lirq_cnt", 32'(d_lirq_cnt), 1);
        check("lirq_pos", d_lirq_pos, 32'({9'd8, 9'd257}));
        d_rec = 1'b0;

        // out-of-range compare, then flip at hn=5, vn=20
        d_irq = 9'd300;
        repeat (11 * 384 + 5) d_tick();
        check("pre_flip_pos", 32'({d_vpos, d_hpos}), 32'({9'd20, 9'd5}));
        check("lirq_quiet", 32'(d_lirq), 0);
        d_flip = 1'b1;
        #1;
        check("flip_hpos", 32'(d_hpos), 32'h1FA);
        check("flip_vpos", 32'(d_vpos), 32'h1EB);
        d_flip = 1'b0;
        #1;
        check("unflip_hpos", 32'(d_hpos), 5);

        // enable every 4th clock: counters freeze between enables
        eh = 9'd5;
        for (int i = 0; i < 24; i++) begin
            d_cen = (i % 4 == 3);
            d_tick();
            if (d_cen) eh = eh + 9'd1;
            if (d_hpos !== eh || d_vpos !== 9'd20) freeze_bad++;
        end
        check("gated_track", 32'(freeze_bad), 0);
        check("gated_hpos", 32'(d_hpos), 11);
        check("gated_m", 32'(d_m), 32'h20);

        // mid-frame reset clears asynchronously, between clock edges
        #2;
        d_rst_n = 1'b0;
        #1;
        check("async_pos", 32'({d_vpos, d_hpos}), 32'({9'd8, 9'd0}));
        check("async_m", 32'(d_m), 0);
        check("async_flags", 32'({d_hbl, d_vbl, d_hs, d_vs, d_lirq, d_frame}), 0);
        @(posedge clk); #1;
        d_rst_n = 1'b1;
        d_cen   = 1'b1;
        d_tick();
        check("restart_pos", 32'({d_vpos, d_hpos}), 32'({9'd8, 9'd1}));

        // whole frame on the small timer, line compare at 20
        s_rst_n = 1'b1;
        repeat (33 * 32) s_tick();
        check("s_frame_end", 32'({s_vpos, s_hpos}), 32'({9'd8, 9'd0}));
        check("s_vbl_rise", s_vbl_rise, 32'({9'd36, 9'd0}));
        check("s_vbl_fall", s_vbl_fall, 32'({9'd8, 9'd0}));
        check("s_vs_rise", s_vs_rise, 32'({9'd37, 9'd27}));
        check("s_vs_fall", s_vs_fall, 32'({9'd39, 9'd27}));
        check("s_frame_cnt", 32'(s_frame_cnt), 1);
        check("s_frame_pos", s_frame_pos, 32'({9'd36, 9'd0}));
        check("s_lirq_cnt", 32'(s_lirq_cnt), 1);
        check("s_lirq_pos", s_lirq_pos, 32'({9'd20, 9'd25}));
        check("s_hbl_rise", s_hbl_rise, 25);
        check("s_m_pattern", 32'(s_m_bad), 0);
        check("s_end_flags", 32'({s_hbl, s_vbl, s_hs, s_vs}), 0);

        // second frame with an unreachable compare line
        s_irq       = 9'd300;
        s_lirq_cnt  = 0;
        s_frame_cnt = 0;
        repeat (33 * 32) s_tick();
        check("s_lirq_none", 32'(s_lirq_cnt), 0);
        check("s_frame_cnt2", 32'(s_frame_cnt), 1);
        check("s_frame_end2", 32'({s_vpos, s_hpos}), 32'({9'd8, 9'd0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
